// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int GRANT_CNT_W = 16;

  // Index width that never collapses to zero bits, so single-bit selects stay legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/consumer bundle of the register write arbiter.
// slave = arbiter side, master = producers/consumer side.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8
) ();

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATAWIDTH-1:0] d;
  logic [NUM_REQ-1:0]           gnt;
  logic [DATAWIDTH-1:0]         q;
  logic                         q_valid;
  logic [IDX_W-1:0]             q_src;
  logic                         q_ack;

  modport slave (
    input  req, d, q_ack,
    output gnt, q, q_valid, q_src
  );

  modport master (
    output req, d, q_ack,
    input  gnt, q, q_valid, q_src
  );

endinterface

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic found;
  int   cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    gnt     = found ? (NUM_REQ'(1) << win_idx) : '0;
    any_req = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one holding register among NUM_REQ producers.
// Optional 16-bit saturating grant counter under REG_WRITE_ARBITER_STATS_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  reg_write_arbiter_if.slave      bus
`ifdef REG_WRITE_ARBITER_STATS_EN
  ,
  output logic [GRANT_CNT_W-1:0]  grant_count
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DATAWIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0]     q_src_q, q_src_d;

  logic [DATAWIDTH-1:0] d_lane [NUM_REQ];
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic                 can_load;
  logic                 grant_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign d_lane[gi] = bus.d[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // A full register may be reloaded on the same edge the consumer acks it.
  assign can_load   = (state_q == ST_EMPTY) || bus.q_ack;
  assign grant_fire = can_load && any_req && Rst;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    q_src_d = q_src_q;
    if (grant_fire) begin
      state_d = ST_FULL;
      q_d     = d_lane[win_idx];
      q_src_d = win_idx;
      ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (state_q == ST_FULL && bus.q_ack) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      q_q     <= '0;
      q_src_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      q_src_q <= q_src_d;
    end
  end

  assign bus.gnt     = grant_fire ? pick_gnt : '0;
  assign bus.q       = q_q;
  assign bus.q_valid = (state_q == ST_FULL);
  assign bus.q_src   = q_src_q;

`ifdef REG_WRITE_ARBITER_STATS_EN
  logic [GRANT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_fire && (cnt_q != {GRANT_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected loads,
// a negedge monitor pops them whenever a new value is presented on q.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(N), .DATAWIDTH(W)) bus ();

`ifdef REG_WRITE_ARBITER_STATS_EN
  logic [GRANT_CNT_W-1:0] grant_count;
`endif

  reg_write_arbiter #(
    .NUM_REQ   (N),
    .DATAWIDTH (W)
  ) dut (
    .Clk         (clk),
    .Rst         (rst_n),
    .bus         (bus)
`ifdef REG_WRITE_ARBITER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  int    checks   = 0;
  int    failures = 0;
  item_t exp_q[$];
  item_t mon_e;
  bit    prev_valid = 1'b0;
  bit    prev_ack   = 1'b0;
  logic [W-1:0] dv [N] = '{8'h11, 8'h22, 8'hA5, 8'h44};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (bus.q_valid && (!prev_valid || prev_ack)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load: got q=0x%0h src=%0d expected no load", bus.q, bus.q_src);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_q", 32'(bus.q), 32'(mon_e.data));
          chk("sb_q_src", 32'(bus.q_src), 32'(mon_e.src));
        end
        $display("load q=0x%0h src=%0d", bus.q, bus.q_src);
      end
      prev_valid = bus.q_valid;
      prev_ack   = bus.q_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic a);
    bus.req   = r;
    bus.q_ack = a;
    #1;
  endtask

  task automatic grant(input string name, input int w);
    item_t e;
    chk(name, 32'(bus.gnt), 32'(1) << w);
    e.data = dv[w];
    e.src  = 2'(w);
    exp_q.push_back(e);
  endtask

  task automatic release_reset();
    drive(4'b0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.d     = {dv[3], dv[2], dv[1], dv[0]};
    bus.req   = 4'b1111;
    bus.q_ack = 1'b0;
    #2;
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_q_valid", 32'(bus.q_valid), 32'h0);
    chk("rst_q_src", 32'(bus.q_src), 32'h0);
    chk("rst_gnt_gated", 32'(bus.gnt), 32'h0);
    release_reset();

    // single request from EMPTY
    drive(4'b0100, 1'b0);
    grant("single_gnt", 2);
    tick();
    drive(4'b0000, 1'b0);
    chk("single_q_valid", 32'(bus.q_valid), 32'h1);
    tick();

    // FULL without ack never grants; async reset mid-cycle clears everything
    drive(4'b1111, 1'b0);
    chk("full_no_ack_gnt", 32'(bus.gnt), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(bus.q), 32'h0);
    chk("midrst_q_valid", 32'(bus.q_valid), 32'h0);
    chk("midrst_q_src", 32'(bus.q_src), 32'h0);
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    release_reset();

    // round-robin with all requesting and continuous ack
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1);
      grant($sformatf("rr_gnt%0d", k), k % 4);
      chk($sformatf("rr_valid%0d", k), 32'(bus.q_valid), (k > 0) ? 32'h1 : 32'h0);
      tick();
    end
    drive(4'b0000, 1'b1);
    chk("rr_last_valid", 32'(bus.q_valid), 32'h1);
    tick();
    drive(4'b0000, 1'b1);
    chk("empty_ack_valid", 32'(bus.q_valid), 32'h0);
    chk("empty_ack_gnt", 32'(bus.gnt), 32'h0);
    tick();
    chk("empty_keep_valid", 32'(bus.q_valid), 32'h0);
    chk("empty_keep_q", 32'(bus.q), 32'h11);
    chk("empty_keep_src", 32'(bus.q_src), 32'h0);

    // backpressure: ptr=1, FULL held for 5 cycles
    drive(4'b0011, 1'b0);
    grant("bp_first", 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0011, 1'b0);
      chk($sformatf("bp_gnt%0d", k), 32'(bus.gnt), 32'h0);
      chk($sformatf("bp_q%0d", k), 32'(bus.q), 32'h22);
      tick();
    end
    drive(4'b0011, 1'b1);
    grant("bp_release", 0);
    tick();
    drive(4'b0000, 1'b1);
    chk("bp_reload_valid", 32'(bus.q_valid), 32'h1);
    tick();
    drive(4'b0000, 1'b0);
    chk("bp_drained", 32'(bus.q_valid), 32'h0);

    // wrap and skip: ptr=1 -> 3 -> 2 -> 3 -> 0 -> 1
    drive(4'b0100, 1'b0);
    grant("wrap_set_ptr3", 2);
    tick();
    drive(4'b0010, 1'b1);
    grant("skip_ptr3_req1", 1);
    tick();
    drive(4'b0100, 1'b1);
    grant("ptr2_req2", 2);
    tick();
    drive(4'b1000, 1'b1);
    grant("wrap_ptr3_req3", 3);
    tick();
    drive(4'b1001, 1'b1);
    grant("after_wrap_ptr0", 0);
    tick();
    drive(4'b1010, 1'b1);
    grant("ptr1_req13", 1);
    tick();
    drive(4'b0000, 1'b1);
    tick();
    drive(4'b0000, 1'b0);
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

`ifdef REG_WRITE_ARBITER_STATS_EN
    rst_n = 1'b0;
    release_reset();
    chk("cnt_rst", 32'(grant_count), 32'h0);
    drive(4'b0001, 1'b1);
    for (int k = 0; k < 65540; k++) begin
      mon_e.data = dv[0];
      mon_e.src  = 2'd0;
      exp_q.push_back(mon_e);
      tick();
      if (k == 9) chk("cnt_10", 32'(grant_count), 32'd10);
    end
    chk("cnt_sat", 32'(grant_count), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("cnt_clear", 32'(grant_count), 32'h0);
    exp_q.delete();
    release_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
